pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have port: clock  input  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  reset; asynchronous, active-high.
REQ-003 SHALL have port: start  input  1  level; launches execution from IDLE.
REQ-004 SHALL have port: pc_actual  input  11  current value of the program counter register.
REQ-005 SHALL have port: stall  input  1  hazard-unit freeze request.
REQ-006 SHALL have ports: branch_taken  input  1; branch_target  input  11  resolved conditional redirect.
REQ-007 SHALL have ports: jump  input  1; jump_target  input  11  unconditional redirect.
REQ-008 SHALL have port: halt_instr  input  1  halt opcode decoded in the current cycle.
REQ-009 SHALL have ports: siguiente_pc  output  11; enable_pc  output  1  drive the PC register's next-value and load-enable inputs.
REQ-010 SHALL have port: flush_if_id  output  1  kills the fetched instruction on redirect.
REQ-011 SHALL have ports: running  output  1; halted  output  1  state flags.
REQ-012 SHALL have port: instr_count  output  16  number of accepted PC updates since reset.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, HALT; IDLE->RUN on start=1; RUN->HALT on accepted halt_instr; HALT is terminal until reset.
REQ-014 SHALL drive enable_pc=0 in IDLE and HALT; siguiente_pc=pc_actual there.
REQ-015 In RUN, SHALL select next PC by priority: branch_taken -> branch_target; else jump -> jump_target; else stall -> enable_pc=0; else pc_actual+1.
REQ-016 Redirects SHALL override stall: enable_pc=1 when branch_taken or jump, regardless of stall.
REQ-017 Sequential increment SHALL be 11-bit modulo: 2047+1 -> 0, no error flag.
REQ-018 siguiente_pc, enable_pc, flush_if_id SHALL be combinational from state and inputs (zero latency); the PC register captures on the same rising edge.
REQ-019 flush_if_id SHALL be 1 exactly in RUN cycles where branch_taken or jump is 1.
REQ-020 halt_instr SHALL be ignored in a cycle with branch_taken or jump (wrong-path halt); otherwise halt_instr in RUN forces enable_pc=0 and transitions to HALT next edge, even if stall=1.
REQ-021 instr_count SHALL increment on each edge where enable_pc=1, saturating at 16'hFFFF.
REQ-022 running=1 iff state is RUN; halted=1 iff state is HALT (registered, state-derived).

Reset
REQ-023 Reset SHALL asynchronously force state IDLE and instr_count=0; outputs then read enable_pc=0, flush_if_id=0, running=0, halted=0.
REQ-024 Reset asserted mid-RUN or mid-HALT SHALL abandon operation; execution resumes only after reset release and a new start.

Configuration
REQ-025 Macro PC_SEQUENCER_STEP_EN SHALL, when defined, add inputs step_mode (1) and step (1): in RUN with step_mode=1, enable_pc and flush_if_id are forced 0 unless step=1, and halt_instr is only accepted on step=1 cycles; with step_mode=0 behaviour equals the base design.
REQ-026 Without PC_SEQUENCER_STEP_EN, step_mode/step ports SHALL be absent and behaviour SHALL be as step_mode=0.

Structure
REQ-027 Shared package pipeline_pkg SHALL hold PC_WIDTH=11, RESET_PC=0, COUNT_WIDTH=16 and the FSM state encoding.
REQ-028 Next-PC priority mux plus incrementer SHALL be a sub-module pc_next_mux (purely combinational); the FSM and counter stay in pc_sequencer.

Verification
REQ-029 Reset, start=1 with pc_actual=0 and no hazards for 3 cycles -> siguiente_pc 1,2,3 (PC register follows), enable_pc=1, instr_count=3.
REQ-030 RUN, stall=1 and branch_taken=1, branch_target=0x40 -> enable_pc=1, siguiente_pc=0x40, flush_if_id=1; stall alone next cycle -> enable_pc=0.
REQ-031 branch_taken=1 (target 0x10) and jump=1 (target 0x20) together -> siguiente_pc=0x10.
REQ-032 pc_actual=0x7FF, no hazards -> siguiente_pc=0x000.
REQ-033 halt_instr=1 with jump=1 -> jump taken, stays RUN; halt_instr alone next cycle -> enable_pc=0, halted=1 after edge; reset mid-HALT -> IDLE, instr_count=0.
REQ-034 With PC_SEQUENCER_STEP_EN, step_mode=1, step pulsed 1 cycle in 5 -> exactly one PC advance per pulse, instr_count +1 per pulse.

Source files
------------

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared widths, the reset PC and the sequencer FSM encoding.
// Used by pc_sequencer_if, pc_next_mux and pc_sequencer.
// Build option: PC_SEQUENCER_STEP_EN adds single-step inputs to the sequencer.
package pipeline_pkg;

  localparam int PC_WIDTH    = 11;
  localparam int RESET_PC    = 0;
  localparam int COUNT_WIDTH = 16;

  typedef logic [PC_WIDTH-1:0]    pc_t;
  typedef logic [COUNT_WIDTH-1:0] count_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } seq_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: bundle of the PC sequencer's control and PC signals.
//   master modport : the surrounding pipeline (drives start/hazards/redirects,
//                    reads next-PC, enables, flags and count)
//   slave modport  : pc_sequencer itself
// Build option: PC_SEQUENCER_STEP_EN adds step_mode and step (master -> slave).
interface pc_sequencer_if;
  import pipeline_pkg::*;

  logic   start;
  pc_t    pc_actual;
  logic   stall;
  logic   branch_taken;
  pc_t    branch_target;
  logic   jump;
  pc_t    jump_target;
  logic   halt_instr;
  pc_t    siguiente_pc;
  logic   enable_pc;
  logic   flush_if_id;
  logic   running;
  logic   halted;
  count_t instr_count;

`ifdef PC_SEQUENCER_STEP_EN
  logic   step_mode;
  logic   step;

  modport master (
    output start, pc_actual, stall, branch_taken, branch_target,
           jump, jump_target, halt_instr, step_mode, step,
    input  siguiente_pc, enable_pc, flush_if_id, running, halted, instr_count
  );
  modport slave (
    input  start, pc_actual, stall, branch_taken, branch_target,
           jump, jump_target, halt_instr, step_mode, step,
    output siguiente_pc, enable_pc, flush_if_id, running, halted, instr_count
  );
`else
  modport master (
    output start, pc_actual, stall, branch_taken, branch_target,
           jump, jump_target, halt_instr,
    input  siguiente_pc, enable_pc, flush_if_id, running, halted, instr_count
  );
  modport slave (
    input  start, pc_actual, stall, branch_taken, branch_target,
           jump, jump_target, halt_instr,
    output siguiente_pc, enable_pc, flush_if_id, running, halted, instr_count
  );
`endif

endinterface

// File: rtl/pc_next_mux.sv
// pc_next_mux: purely combinational next-PC priority selector.
//   pc_actual                    : current PC
//   branch_taken/branch_target   : highest-priority redirect
//   jump/jump_target             : second-priority redirect
//   stall                        : freeze when no redirect is present
//   next_pc                      : selected next PC (pc_actual+1 wraps at 11 bits)
//   load                         : 1 when next_pc should be loaded
module pc_next_mux
  import pipeline_pkg::*;
(
  input  pc_t  pc_actual,
  input  logic branch_taken,
  input  pc_t  branch_target,
  input  logic jump,
  input  pc_t  jump_target,
  input  logic stall,
  output pc_t  next_pc,
  output logic load
);

  always_comb begin
    next_pc = pc_actual;
    load    = 1'b0;
    if (branch_taken) begin
      next_pc = branch_target;
      load    = 1'b1;
    end else if (jump) begin
      next_pc = jump_target;
      load    = 1'b1;
    end else if (!stall) begin
      // natural PC_WIDTH overflow gives the 2047 -> 0 wrap
      next_pc = pc_actual + pc_t'(1);
      load    = 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: IDLE/RUN/HALT control of the program counter.
//   clock, reset : system clock; asynchronous active-high reset
//   bus (slave)  : start, pc_actual, stall, branch/jump redirects, halt_instr in;
//                  siguiente_pc, enable_pc, flush_if_id, running, halted,
//                  instr_count out
// Build option: PC_SEQUENCER_STEP_EN gates PC updates and halt acceptance to
// cycles with step=1 while step_mode=1.
module pc_sequencer
  import pipeline_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);

  seq_state_e state_q, state_d;
  count_t     count_q, count_d;

  pc_t  mux_pc;
  logic mux_load;
  logic step_ok;
  logic redirect;
  logic enable_c;
  logic flush_c;
  pc_t  next_pc_c;

  pc_next_mux u_next_mux (
    .pc_actual     (bus.pc_actual),
    .branch_taken  (bus.branch_taken),
    .branch_target (bus.branch_target),
    .jump          (bus.jump),
    .jump_target   (bus.jump_target),
    .stall         (bus.stall),
    .next_pc       (mux_pc),
    .load          (mux_load)
  );

`ifdef PC_SEQUENCER_STEP_EN
  assign step_ok = !bus.step_mode || bus.step;
`else
  assign step_ok = 1'b1;
`endif

  assign redirect = bus.branch_taken || bus.jump;

  always_comb begin
    state_d   = state_q;
    enable_c  = 1'b0;
    flush_c   = 1'b0;
    next_pc_c = bus.pc_actual;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN: begin
        if (step_ok) begin
          // a halt decoded alongside a redirect is on the wrong path
          if (bus.halt_instr && !redirect) begin
            state_d = ST_HALT;
          end else begin
            enable_c = mux_load;
            flush_c  = redirect;
            if (mux_load) next_pc_c = mux_pc;
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  assign count_d = (enable_c && (count_q != '1)) ? count_q + count_t'(1) : count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign bus.siguiente_pc = next_pc_c;
  assign bus.enable_pc    = enable_c;
  assign bus.flush_if_id  = flush_c;
  assign bus.running      = (state_q == ST_RUN);
  assign bus.halted       = (state_q == ST_HALT);
  assign bus.instr_count  = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer. Each cycle the bench
// drives the inputs, pushes the expected outputs from its own model and pops
// and compares them on the falling edge. The bench plays the PC register.
// Build option: PC_SEQUENCER_STEP_EN enables the single-step section.
module tb_pc_sequencer;

  logic clock;
  logic reset;

  pc_sequencer_if bus();

  pc_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [10:0] spc;
    logic        en;
    logic        fl;
    logic        run;
    logic        hlt;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  int total = 0;
  int bad   = 0;

  // model state: 0 idle, 1 run, 2 halt
  int          m_state;
  logic [10:0] m_pc;
  logic [15:0] m_cnt;
  logic        sm;
  logic        st;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
    end
  endtask

  task automatic run_cycle(input string tag, input logic s, input logic stl,
                           input logic br, input logic [10:0] bt,
                           input logic j, input logic [10:0] jt, input logic h);
    exp_t        e;
    exp_t        got;
    logic        ok;
    logic        hacc;
    logic        ld;
    logic        run;
    logic [10:0] nxt;
    bus.start         = s;
    bus.stall         = stl;
    bus.branch_taken  = br;
    bus.branch_target = bt;
    bus.jump          = j;
    bus.jump_target   = jt;
    bus.halt_instr    = h;
    bus.pc_actual     = m_pc;
`ifdef PC_SEQUENCER_STEP_EN
    bus.step_mode     = sm;
    bus.step          = st;
`endif
    run  = (m_state == 1);
    ok   = !sm || st;
    hacc = run && h && !(br || j) && ok;
    if (br)        begin nxt = bt;          ld = 1'b1; end
    else if (j)    begin nxt = jt;          ld = 1'b1; end
    else if (stl)  begin nxt = m_pc;        ld = 1'b0; end
    else           begin nxt = m_pc + 11'd1; ld = 1'b1; end
    e.en  = run && ok && !hacc && ld;
    e.fl  = run && ok && !hacc && (br || j);
    e.spc = e.en ? nxt : m_pc;
    e.run = (m_state == 1);
    e.hlt = (m_state == 2);
    e.cnt = m_cnt;
    sb_q.push_back(e);

    #4;
    got = sb_q.pop_front();
    $display("%s pc=%03h spc=%03h en=%b fl=%b run=%b hlt=%b cnt=%0d", tag, m_pc,
             bus.siguiente_pc, bus.enable_pc, bus.flush_if_id, bus.running,
             bus.halted, bus.instr_count);
    check_val({tag, ".spc"}, 32'(bus.siguiente_pc), 32'(got.spc));
    check_val({tag, ".en"},  32'(bus.enable_pc),    32'(got.en));
    check_val({tag, ".fl"},  32'(bus.flush_if_id),  32'(got.fl));
    check_val({tag, ".run"}, 32'(bus.running),      32'(got.run));
    check_val({tag, ".hlt"}, 32'(bus.halted),       32'(got.hlt));
    check_val({tag, ".cnt"}, 32'(bus.instr_count),  32'(got.cnt));

    @(posedge clock);
    #1;
    if (got.en) m_pc = got.spc;
    if (got.en && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    if (m_state == 0 && s)         m_state = 1;
    else if (m_state == 1 && hacc) m_state = 2;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, ".en"},  32'(bus.enable_pc),   32'd0);
    check_val({tag, ".fl"},  32'(bus.flush_if_id), 32'd0);
    check_val({tag, ".run"}, 32'(bus.running),     32'd0);
    check_val({tag, ".hlt"}, 32'(bus.halted),      32'd0);
    check_val({tag, ".cnt"}, 32'(bus.instr_count), 32'd0);
  endtask

  initial begin
    m_state = 0;
    m_pc    = 11'd0;
    m_cnt   = 16'd0;
    sm      = 1'b0;
    st      = 1'b0;
    bus.start         = 1'b1;
    bus.pc_actual     = 11'd0;
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 11'h55;
    bus.jump          = 1'b0;
    bus.jump_target   = 11'd0;
    bus.halt_instr    = 1'b0;
`ifdef PC_SEQUENCER_STEP_EN
    bus.step_mode     = 1'b0;
    bus.step          = 1'b0;
`endif
    reset = 1'b1;
    #12;
    check_reset_outputs("reset");
    @(posedge clock);
    #1;
    reset = 1'b0;

    // launch and three sequential fetches
    run_cycle("start", 1, 0, 0, 11'h0, 0, 11'h0, 0);
    for (int i = 0; i < 3; i++) run_cycle("seq", 1, 0, 0, 11'h0, 0, 11'h0, 0);

    // redirect overrides stall, then stall alone freezes
    run_cycle("stall_br", 1, 1, 1, 11'h040, 0, 11'h0, 0);
    run_cycle("stall",    1, 1, 0, 11'h0,   0, 11'h0, 0);

    // branch beats jump
    run_cycle("br_jmp", 1, 0, 1, 11'h010, 1, 11'h020, 0);

    // 11-bit wrap
    m_pc = 11'h7FF;
    run_cycle("wrap", 1, 0, 0, 11'h0, 0, 11'h0, 0);
    run_cycle("seq2", 1, 0, 0, 11'h0, 0, 11'h0, 0);
    run_cycle("jmp",  1, 1, 0, 11'h0, 1, 11'h100, 0);

`ifdef PC_SEQUENCER_STEP_EN
    // single step: one advance per step pulse; an unstepped halt is ignored
    sm = 1'b1;
    for (int i = 0; i < 10; i++) begin
      st = (i % 5 == 4);
      run_cycle("step", 1, 0, 0, 11'h0, (i == 2), 11'h300, (i == 1));
    end
    sm = 1'b0;
    st = 1'b0;
`endif

    // wrong-path halt ignored, then a real halt even under stall
    run_cycle("halt_jmp", 1, 0, 0, 11'h0, 1, 11'h200, 1);
    run_cycle("halt",     1, 1, 0, 11'h0, 0, 11'h0,   1);
    run_cycle("halted",   1, 0, 0, 11'h0, 0, 11'h0,   0);
    run_cycle("halted2",  1, 0, 1, 11'h070, 0, 11'h0, 0);

    // asynchronous reset in HALT
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_halt");
    m_state = 0;
    m_cnt   = 16'd0;
    @(posedge clock);
    #1;
    reset = 1'b0;

    run_cycle("idle_nostart", 0, 0, 0, 11'h0, 0, 11'h0, 0);
    run_cycle("restart",      1, 0, 0, 11'h0, 0, 11'h0, 0);
    run_cycle("resume",       1, 0, 0, 11'h0, 0, 11'h0, 0);
    run_cycle("resume2",      0, 0, 0, 11'h0, 0, 11'h0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
